// File: rtl/data_mem_unit.sv
// Wait-stated single-port data memory with a one-cycle mem_ready completion pulse.
// Optional out-of-range address checking is compiled in with MEM_RANGE_CHECK_EN.
module data_mem_unit #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Bus_A,
  input  logic [31:0] Bus_B,
  input  logic        MR,
  input  logic        MW,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            write_q;
  logic            err_q;
  logic            range_err;
  logic            capture;
  logic            access;
  logic [31:0]     mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
  assign range_err = |Bus_A[31:AW];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^Bus_A[31:AW];
  assign range_err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MR | MW) begin
          capture = 1'b1;
          cnt_d   = WAIT_STATES[3:0];
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      data_out <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= Bus_A[AW-1:0];
        wdata_q <= Bus_B;
        // A simultaneous MR+MW is treated as a write.
        write_q <= MW;
        err_q   <= range_err;
      end
      if (access && !write_q) begin
        data_out <= err_q ? 32'h0 : mem[addr_q];
      end
    end
  end

  // Array is not reset; writes only commit on the access edge.
  always_ff @(posedge clk) begin
    if (access && write_q && !err_q && !reset) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign mem_ready = (state_q == StDone);
  assign busy      = (state_q != StIdle);

`ifdef MEM_RANGE_CHECK_EN
  assign addr_err = (state_q == StDone) & err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
module tb_data_mem_unit;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] a2, b2, d2, a0, b0, d0;
  logic        mr2, mw2, rdy2, busy2, err2;
  logic        mr0, mw0, rdy0, busy0, err0;
  int          errors;
  int          checks;

  data_mem_unit #(.DEPTH(256), .AW(8), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .Bus_A(a2), .Bus_B(b2), .MR(mr2), .MW(mw2),
    .data_out(d2), .mem_ready(rdy2), .busy(busy2), .addr_err(err2)
  );

  data_mem_unit #(.DEPTH(256), .AW(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .Bus_A(a0), .Bus_B(b0), .MR(mr0), .MW(mw0),
    .data_out(d0), .mem_ready(rdy0), .busy(busy0), .addr_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                       input logic r, input logic w);
    if (sel) begin
      a2 = addr; b2 = data; mr2 = r; mw2 = w;
    end else begin
      a0 = addr; b0 = data; mr0 = r; mw0 = w;
    end
  endtask

  // One request, then a fixed window checking handshake position, busy length and addr_err.
  task automatic access(input bit sel, input logic w, input logic r, input logic [31:0] addr,
                        input logic [31:0] data, input logic exp_err, input string tag);
    int ws;
    int rdy_idx;
    int busy_n;
    int rdy_n;
    int err_n;
    ws      = sel ? 2 : 0;
    rdy_idx = -1;
    busy_n  = 0;
    rdy_n   = 0;
    err_n   = 0;
    @(negedge clk);
    drive(sel, addr, data, r, w);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) drive(sel, addr, data, 1'b0, 1'b0);
      if (sel ? busy2 : busy0) busy_n++;
      if (sel ? rdy2 : rdy0) begin
        rdy_n++;
        if (rdy_idx < 0) rdy_idx = i;
      end
      if (sel ? err2 : err0) err_n++;
    end
    chk({tag, "_rdy_pos"}, rdy_idx, ws + 1);
    chk({tag, "_rdy_len"}, rdy_n, 1);
    chk({tag, "_busy_len"}, busy_n, ws + 2);
    chk({tag, "_addr_err"}, err_n, {31'd0, exp_err});
  endtask

  initial begin
    int rdy_n;
    int first_idx;
    int last_idx;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_dout2", d2, 32'h0);
    chk("rst_rdy2", {31'd0, rdy2}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_err2", {31'd0, err2}, 32'd0);
    chk("rst_dout0", d0, 32'h0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    reset = 1'b0;

    // Reset aborts an in-flight write.
    access(1'b1, 1'b1, 1'b0, 32'd5, 32'h1111_1111, 1'b0, "t1_pre");
    @(negedge clk);
    drive(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t1_busy_drop", {31'd0, busy2}, 32'd0);
    chk("t1_rdy_drop", {31'd0, rdy2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1'b1, 1'b0, 1'b1, 32'd5, 32'h0, 1'b0, "t1_rd");
    chk("t1_prior", d2, 32'h1111_1111);

    // WAIT_STATES=2 write then read.
    access(1'b1, 1'b1, 1'b0, 32'd3, 32'h1234_5678, 1'b0, "t2_wr");
    chk("t2_dout_hold", d2, 32'h1111_1111);
    access(1'b1, 1'b0, 1'b1, 32'd3, 32'h0, 1'b0, "t2_rd");
    chk("t2_data", d2, 32'h1234_5678);

    // WAIT_STATES=0: write, then MR held high re-accepts every 3 cycles.
    access(1'b0, 1'b1, 1'b0, 32'd255, 32'hA5A5_A5A5, 1'b0, "t3_wr");
    rdy_n     = 0;
    first_idx = -1;
    last_idx  = -1;
    @(negedge clk);
    drive(1'b0, 32'd255, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdy0) begin
        rdy_n++;
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
    end
    drive(1'b0, 32'd255, 32'h0, 1'b0, 1'b0);
    chk("t3_rdy_count", rdy_n, 4);
    chk("t3_rdy_first", first_idx, 1);
    chk("t3_rdy_last", last_idx, 10);
    chk("t3_data", d0, 32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    chk("t3_idle", {31'd0, busy0}, 32'd0);

    // MR+MW together performs a write and leaves data_out alone.
    access(1'b1, 1'b1, 1'b1, 32'd7, 32'h0000_0042, 1'b0, "t4_both");
    chk("t4_dout_hold", d2, 32'h1234_5678);
    access(1'b1, 1'b0, 1'b1, 32'd7, 32'h0, 1'b0, "t4_rd");
    chk("t4_data", d2, 32'h0000_0042);

    // Bus changes during BUSY are ignored.
    access(1'b1, 1'b1, 1'b0, 32'd10, 32'hCAFE_F00D, 1'b0, "t5_pre");
    @(negedge clk);
    drive(1'b1, 32'd9, 32'h1, 1'b0, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 32'd10, 32'h2, 1'b1, 1'b1);
      if (i == 3) begin
        chk("t5_rdy", {31'd0, rdy2}, 32'd1);
        drive(1'b1, 32'd10, 32'h2, 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    chk("t5_no_reaccept", {31'd0, busy2}, 32'd0);
    access(1'b1, 1'b0, 1'b1, 32'd9, 32'h0, 1'b0, "t5_rd9");
    chk("t5_mem9", d2, 32'h1);
    access(1'b1, 1'b0, 1'b1, 32'd10, 32'h0, 1'b0, "t5_rd10");
    chk("t5_mem10", d2, 32'hCAFE_F00D);

    // Upper address bits: wrap by default, flagged with range checking.
    access(1'b1, 1'b1, 1'b0, 32'h0000_0105, 32'h77, RC, "t6_wr");
    access(1'b1, 1'b0, 1'b1, 32'd5, 32'h0, 1'b0, "t6_rd5");
    chk("t6_mem5", d2, RC ? 32'h1111_1111 : 32'h77);
    access(1'b1, 1'b0, 1'b1, 32'h0000_0105, 32'h0, RC, "t6_rd105");
    chk("t6_rd105_data", d2, RC ? 32'h0 : 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
